// File: rtl/telemetry_pkg.sv
// Shared types for the telemetry slot scheduler.
// Packet width, FSM state encoding, saturating counter helper.
`timescale 1ns/1ps
package telemetry_pkg;

  localparam int TELEM_PKT_W = 88;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_WAIT_RDY
  } sched_state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        en
  );
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/telemetry_scheduler_if.sv
// Source/serializer handshake bundle of the telemetry scheduler.
// master: trigger/packet/packet_valid out; slave: data/valid/ready out.
`timescale 1ns/1ps
interface telemetry_scheduler_if #(
  parameter int N_SRC = 2,
  parameter int PKT_W = telemetry_pkg::TELEM_PKT_W
);
  logic [N_SRC-1:0]       src_trigger;
  logic [N_SRC*PKT_W-1:0] src_data;
  logic [N_SRC-1:0]       src_valid;
  logic                   serializer_ready;
  logic [PKT_W-1:0]       packet;
  logic                   packet_valid;

  modport master (
    output src_trigger, packet, packet_valid,
    input  src_data, src_valid, serializer_ready
  );

  modport slave (
    input  src_trigger, packet, packet_valid,
    output src_data, src_valid, serializer_ready
  );
endinterface

// File: rtl/telemetry_rate_tick.sv
// Slot-rate timer: counts 0..rate-1 and ticks when count==rate-1.
// Ports: clk, reset_clk (sync, active-high), rate, tick.
`timescale 1ns/1ps
module telemetry_rate_tick #(
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              reset_clk,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] cnt;
  logic [RATE_W-1:0] last;

  assign last = rate - RATE_W'(1);
  assign tick = !reset_clk && (rate != '0) && (cnt == last);

  // A rate lowered below the current count wraps without a tick.
  always_ff @(posedge clk) begin
    if (reset_clk)
      cnt <= '0;
    else if (rate == '0 || cnt >= last)
      cnt <= '0;
    else
      cnt <= cnt + RATE_W'(1);
  end

endmodule

// File: rtl/telemetry_scheduler.sv
// Round-robin slot scheduler sharing one serializer between N_SRC sources.
// Ports: clk, reset_clk, rate, bus (master), busy, err_*, stat_*.
// Optional stats counters: define TELEMETRY_SCHED_STATS_EN.
`timescale 1ns/1ps
module telemetry_scheduler
  import telemetry_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int PKT_W   = TELEM_PKT_W,
  parameter int RATE_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_clk,
  input  logic [RATE_W-1:0]    rate,
  telemetry_scheduler_if.master bus,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_overrun,
  output logic [15:0]          stat_sent,
  output logic [15:0]          stat_timeout,
  output logic [15:0]          stat_overrun
);

  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int TW = $clog2(TIMEOUT);

  sched_state_t     state, state_n;
  logic [GW-1:0]    grant;
  logic             pending;
  logic [TW-1:0]    wcnt;
  logic [PKT_W-1:0] pkt_q;
  logic             tick;
  logic             consume;
  logic             cap;
  logic             adv;
  logic [N_SRC-1:0] trig;
  logic             pv;
  logic             to;

  telemetry_rate_tick #(.RATE_W(RATE_W)) u_tick (
    .clk      (clk),
    .reset_clk(reset_clk),
    .rate     (rate),
    .tick     (tick)
  );

  // Strobes are masked during reset so an aborted slot emits nothing.
  always_comb begin
    state_n = state;
    trig    = '0;
    pv      = 1'b0;
    to      = 1'b0;
    cap     = 1'b0;
    adv     = 1'b0;
    consume = 1'b0;
    if (!reset_clk) begin
      unique case (state)
        S_IDLE: begin
          if (pending) begin
            consume = 1'b1;
            trig    = N_SRC'(1) << grant;
            state_n = S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (bus.src_valid[grant]) begin
            cap     = 1'b1;
            state_n = S_WAIT_RDY;
          end else if (wcnt == TW'(TIMEOUT - 1)) begin
            to      = 1'b1;
            adv     = 1'b1;
            state_n = S_IDLE;
          end
        end
        S_WAIT_RDY: begin
          if (bus.serializer_ready) begin
            pv      = 1'b1;
            adv     = 1'b1;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_clk) begin
      state   <= S_IDLE;
      grant   <= '0;
      pending <= 1'b0;
      wcnt    <= '0;
      pkt_q   <= '0;
    end else begin
      state   <= state_n;
      pending <= tick | (pending & ~consume);
      wcnt    <= (state == S_WAIT_DATA) ? wcnt + TW'(1) : '0;
      if (cap)
        pkt_q <= bus.src_data[grant*PKT_W +: PKT_W];
      if (adv)
        grant <= (grant == GW'(N_SRC - 1)) ? '0 : grant + GW'(1);
    end
  end

  assign bus.src_trigger  = trig;
  assign bus.packet       = pkt_q;
  assign bus.packet_valid = pv;
  assign busy             = (state != S_IDLE);
  assign err_timeout      = to;
  // A tick that lands while the previous one is still queued is lost.
  assign err_overrun      = tick & pending & ~consume;

`ifdef TELEMETRY_SCHED_STATS_EN
  logic [15:0] n_sent, n_to, n_ov;

  always_ff @(posedge clk) begin
    if (reset_clk) begin
      n_sent <= '0;
      n_to   <= '0;
      n_ov   <= '0;
    end else begin
      n_sent <= sat_inc(n_sent, pv);
      n_to   <= sat_inc(n_to, to);
      n_ov   <= sat_inc(n_ov, err_overrun);
    end
  end

  assign stat_sent    = n_sent;
  assign stat_timeout = n_to;
  assign stat_overrun = n_ov;
`else
  assign stat_sent    = '0;
  assign stat_timeout = '0;
  assign stat_overrun = '0;
`endif

endmodule
